// File: rtl/fpga_i2c_pkg.sv
// rtl/fpga_i2c_pkg.sv - sequencer states, RW encoding and byte-mask helper
package fpga_i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETTLE,
    ST_ISSUE,
    ST_BLIND,
    ST_WAIT_W,
    ST_WAIT_R,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // Low n bytes set; anything outside 1..4 saturates to the obvious extreme.
  function automatic logic [31:0] bytes_mask(input int n);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < n) m[8*i +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/fpga_i2cmaster_burst_tx_if.sv
// rtl/fpga_i2cmaster_burst_tx_if.sv - command, write/read word and I2C master signals of the burst sequencer
interface fpga_i2cmaster_burst_tx_if #(
  parameter int LEN_W = 4
);
  logic             itf_sel_d3;
  logic             cmd_valid;
  logic             cmd_rw;
  logic [31:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [31:0]      wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [31:0]      rd_data;
  logic             rd_valid;
  logic             busy;
  logic             done;
  logic             err;
  logic             i2c_master_busy;
  logic [31:0]      i2c_rd_data;
  logic             i2c_rd_valid;
  logic [6:0]       i2c_slave_addr;
  logic             i2c_master_rw;
  logic [31:0]      i2c_master_addr;
  logic [31:0]      i2c_master_din;
  logic             i2c_master_valid;
  logic             i2aen;
  logic [1:0]       i2ac;
  logic [1:0]       i2dc;

  modport slave (
    input  itf_sel_d3, cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_data, wr_valid,
           i2c_master_busy, i2c_rd_data, i2c_rd_valid,
    output wr_ready, rd_data, rd_valid, busy, done, err,
           i2c_slave_addr, i2c_master_rw, i2c_master_addr, i2c_master_din,
           i2c_master_valid, i2aen, i2ac, i2dc
  );

  modport master (
    output itf_sel_d3, cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_data, wr_valid,
           i2c_master_busy, i2c_rd_data, i2c_rd_valid,
    input  wr_ready, rd_data, rd_valid, busy, done, err,
           i2c_slave_addr, i2c_master_rw, i2c_master_addr, i2c_master_din,
           i2c_master_valid, i2aen, i2ac, i2dc
  );

endinterface

// File: rtl/fpga_i2c_watchdog.sv
// rtl/fpga_i2c_watchdog.sv - stall watchdog; counts enabled cycles since the last clear
module fpga_i2c_watchdog #(
  parameter int unsigned LIMIT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [31:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && !expire) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign expire = en && (r_count >= LIMIT);

endmodule

// File: rtl/fpga_i2cmaster_burst_tx.sv
// rtl/fpga_i2cmaster_burst_tx.sv - I2C burst sequencer: N auto-incrementing register accesses per command
// FPGA_I2C_TIMEOUT_EN builds the stall watchdog and the err output; otherwise err is 0.
module fpga_i2cmaster_burst_tx
  import fpga_i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR     = 7'h2C,
  parameter int          ADDR_BYTES     = 1,
  parameter int          DATA_BYTES     = 1,
  parameter int          LEN_W          = 4,
  parameter int          ADDR_INC       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input logic                      CLK,
  input logic                      rst_n,
  fpga_i2cmaster_burst_tx_if.slave bus
);
  localparam logic [31:0]  A_MASK  = bytes_mask(ADDR_BYTES);
  localparam logic [31:0]  D_MASK  = bytes_mask(DATA_BYTES);
  localparam logic [LEN_W:0] CNT_ONE = (LEN_W + 1)'(1);

  state_t         r_state;
  state_t         w_next;
  logic           r_rw;
  logic [31:0]    r_addr;
  logic [31:0]    r_din;
  logic [31:0]    r_rd_data;
  logic           r_rd_valid;
  logic [LEN_W:0] r_count;
  logic           w_accept;
  logic           w_fetch;
  logic           w_capture;
  logic           w_expire;

  assign w_accept  = (r_state == ST_IDLE) && bus.cmd_valid && !bus.itf_sel_d3;
  assign w_fetch   = (r_state == ST_FETCH) && bus.wr_valid;
  assign w_capture = (r_state == ST_WAIT_R) && (w_next == ST_NEXT);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = (bus.cmd_rw == RW_WRITE) ? ST_FETCH : ST_SETTLE;
      ST_FETCH:  if (bus.wr_valid) w_next = ST_SETTLE;
      ST_SETTLE: if (!bus.i2c_master_busy) w_next = ST_ISSUE;
      ST_ISSUE:  w_next = ST_BLIND;
      // The master raises busy a cycle late, so it is not trusted right after the strobe.
      ST_BLIND:  w_next = (r_rw == RW_WRITE) ? ST_WAIT_W : ST_WAIT_R;
      ST_WAIT_W: if (!bus.i2c_master_busy) w_next = ST_NEXT;
      ST_WAIT_R: if (bus.i2c_rd_valid) w_next = ST_NEXT;
      ST_NEXT: begin
        if (r_count == CNT_ONE) w_next = ST_DONE;
        else                    w_next = (r_rw == RW_WRITE) ? ST_FETCH : ST_SETTLE;
      end
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    if (w_expire) w_next = ST_DONE;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_rw       <= RW_READ;
      r_addr     <= '0;
      r_din      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_count    <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_accept) begin
        r_rw    <= bus.cmd_rw;
        r_addr  <= bus.cmd_addr & A_MASK;
        r_count <= {1'b0, bus.cmd_len} + CNT_ONE;
      end
      if (w_fetch) r_din <= bus.wr_data & D_MASK;
      if (w_capture) begin
        r_rd_data  <= bus.i2c_rd_data & D_MASK;
        r_rd_valid <= 1'b1;
      end
      if (r_state == ST_NEXT) begin
        r_addr  <= (r_addr + 32'(ADDR_INC)) & A_MASK;
        r_count <= r_count - CNT_ONE;
      end
    end
  end

`ifdef FPGA_I2C_TIMEOUT_EN
  logic w_wd_en;
  logic w_wd_clr;
  logic r_err;

  assign w_wd_en  = (r_state == ST_FETCH) || (r_state == ST_SETTLE) ||
                    (r_state == ST_WAIT_W) || (r_state == ST_WAIT_R);
  assign w_wd_clr = (w_next != r_state);

  fpga_i2c_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (CLK),
    .rst_n  (rst_n),
    .clr    (w_wd_clr),
    .en     (w_wd_en),
    .expire (w_expire)
  );

  // err survives the done pulse so software can read it after the burst.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)        r_err <= 1'b0;
    else if (w_accept) r_err <= 1'b0;
    else if (w_expire) r_err <= 1'b1;
  end

  assign bus.err = r_err;
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;

  assign w_expire = 1'b0;
  assign bus.err  = 1'b0;
`endif

  assign bus.wr_ready         = (r_state == ST_FETCH);
  assign bus.busy             = (r_state != ST_IDLE);
  assign bus.done             = (r_state == ST_DONE);
  assign bus.rd_data          = r_rd_data;
  assign bus.rd_valid         = r_rd_valid;
  assign bus.i2c_slave_addr   = SLAVE_ADDR;
  assign bus.i2c_master_rw    = r_rw;
  assign bus.i2c_master_addr  = r_addr;
  assign bus.i2c_master_din   = r_din;
  assign bus.i2c_master_valid = (r_state == ST_ISSUE);
  assign bus.i2aen            = 1'b1;
  assign bus.i2ac             = 2'(ADDR_BYTES - 1);
  assign bus.i2dc             = 2'(DATA_BYTES - 1);

endmodule

// File: tb/tb_fpga_i2cmaster_burst_tx.sv
// tb/tb_fpga_i2cmaster_burst_tx.sv - scoreboard bench for the I2C burst sequencer with a behavioural I2C master
module tb_fpga_i2cmaster_burst_tx;
  import fpga_i2c_pkg::*;

  localparam int LEN_W = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] din;
    logic        rw;
  } iss_t;

  logic CLK   = 1'b0;
  logic rst_n = 1'b0;
  always #5 CLK = ~CLK;

  fpga_i2cmaster_burst_tx_if #(.LEN_W(LEN_W)) bus_a ();
  fpga_i2cmaster_burst_tx_if #(.LEN_W(LEN_W)) bus_b ();

  fpga_i2cmaster_burst_tx #(
    .SLAVE_ADDR(7'h2C), .ADDR_BYTES(1), .DATA_BYTES(1), .LEN_W(LEN_W),
    .ADDR_INC(1), .TIMEOUT_CYCLES(100)
  ) u_dut_a (
    .CLK(CLK), .rst_n(rst_n), .bus(bus_a)
  );

  fpga_i2cmaster_burst_tx #(
    .SLAVE_ADDR(7'h2C), .ADDR_BYTES(2), .DATA_BYTES(2), .LEN_W(LEN_W),
    .ADDR_INC(1), .TIMEOUT_CYCLES(100)
  ) u_dut_b (
    .CLK(CLK), .rst_n(rst_n), .bus(bus_b)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  iss_t        exp_iss[$];
  iss_t        obs_iss[$];
  iss_t        obs_iss_b[$];
  logic [31:0] exp_rd[$];
  logic [31:0] obs_rd[$];
  logic [31:0] model_rd[$];
  logic [31:0] wr_q[$];
  int          done_cnt = 0;
  logic        done_err = 1'b0;
  bit          stuck    = 1'b0;
  bit          hold_wr  = 1'b0;
  bit          saw_busy = 1'b0;

  localparam logic [127:0] RST_A = 128'({8'h01, 2'b00, 2'b00, 7'h2C, 96'h0});

  function automatic iss_t mk(input logic [31:0] addr, input logic [31:0] din, input logic rw);
    iss_t e;
    e.addr = addr;
    e.din  = din;
    e.rw   = rw;
    return e;
  endfunction

  function automatic logic [127:0] snap_a();
    return 128'({bus_a.busy, bus_a.done, bus_a.err, bus_a.wr_ready, bus_a.rd_valid,
                 bus_a.i2c_master_valid, bus_a.i2c_master_rw, bus_a.i2aen, bus_a.i2ac,
                 bus_a.i2dc, bus_a.i2c_slave_addr, bus_a.rd_data, bus_a.i2c_master_addr,
                 bus_a.i2c_master_din});
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observers: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge CLK) begin
    if (bus_a.i2c_master_valid)
      obs_iss.push_back(mk(bus_a.i2c_master_addr,
                           bus_a.i2c_master_rw ? bus_a.i2c_master_din : 32'h0,
                           bus_a.i2c_master_rw));
    if (bus_a.rd_valid) obs_rd.push_back(bus_a.rd_data);
    if (bus_a.done) begin
      done_cnt++;
      done_err = bus_a.err;
    end
    if (bus_b.i2c_master_valid)
      obs_iss_b.push_back(mk(bus_b.i2c_master_addr, bus_b.i2c_master_din, bus_b.i2c_master_rw));
  end

  // Write-word source for DUT A.
  initial begin
    bit pend;
    pend = 1'b0;
    bus_a.wr_valid = 1'b0;
    bus_a.wr_data  = 32'h0;
    forever begin
      @(negedge CLK);
      if (pend && wr_q.size() > 0) wr_q.delete(0);
      pend = 1'b0;
      if (!hold_wr && wr_q.size() > 0) begin
        bus_a.wr_valid = 1'b1;
        bus_a.wr_data  = wr_q[0];
      end else begin
        bus_a.wr_valid = 1'b0;
      end
      if (bus_a.wr_valid && bus_a.wr_ready) pend = 1'b1;
    end
  end

  // Behavioural I2C master for DUT A: 3 busy cycles per access, read data on the last.
  initial begin
    bus_a.i2c_master_busy = 1'b0;
    bus_a.i2c_rd_valid    = 1'b0;
    bus_a.i2c_rd_data     = 32'h0;
    forever begin
      @(negedge CLK);
      bus_a.i2c_rd_valid = 1'b0;
      if (stuck) begin
        bus_a.i2c_master_busy = 1'b1;
      end else if (bus_a.i2c_master_valid) begin
        bus_a.i2c_master_busy = 1'b1;
        repeat (3) @(negedge CLK);
        if (!bus_a.i2c_master_rw) begin
          bus_a.i2c_rd_data  = (model_rd.size() > 0) ? model_rd.pop_front() : 32'hDEAD_0000;
          bus_a.i2c_rd_valid = 1'b1;
        end
        bus_a.i2c_master_busy = 1'b0;
      end else begin
        bus_a.i2c_master_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL tb_timeout: simulation did not finish, observed running expected finished");
    $fatal(1);
  end

  task automatic cmd_a(input logic rw, input logic [31:0] addr, input logic [LEN_W-1:0] len);
    @(negedge CLK);
    bus_a.cmd_rw    = rw;
    bus_a.cmd_addr  = addr;
    bus_a.cmd_len   = len;
    bus_a.cmd_valid = 1'b1;
    @(negedge CLK);
    bus_a.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle_a(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (!bus_a.busy) break;
    end
    chk({tag, "_finish"}, 128'(i < budget), 128'(1));
  endtask

  task automatic drain_iss(input string tag);
    iss_t e;
    iss_t o;
    while (exp_iss.size() > 0) begin
      e = exp_iss.pop_front();
      if (obs_iss.size() > 0) o = obs_iss.pop_front();
      else                    o = 'x;
      chk({tag, "_issue"}, 128'(o), 128'(e));
    end
    chk({tag, "_issue_extra"}, 128'(obs_iss.size()), 128'(0));
    obs_iss.delete();
  endtask

  task automatic drain_rd(input string tag);
    logic [31:0] e;
    logic [31:0] o;
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front();
      if (obs_rd.size() > 0) o = obs_rd.pop_front();
      else                   o = 'x;
      chk({tag, "_rd"}, 128'(o), 128'(e));
    end
    chk({tag, "_rd_extra"}, 128'(obs_rd.size()), 128'(0));
    obs_rd.delete();
  endtask

  logic [31:0] rd_model[4] = '{32'hAB11, 32'hCD22, 32'h0033, 32'hEF44};
  logic [31:0] rd_exp[4]   = '{32'h11, 32'h22, 32'h33, 32'h44};

  initial begin
    int d0;
    int i;
    bus_a.itf_sel_d3 = 1'b0;
    bus_a.cmd_valid  = 1'b0;
    bus_a.cmd_rw     = 1'b0;
    bus_a.cmd_addr   = 32'h0;
    bus_a.cmd_len    = '0;
    bus_b.itf_sel_d3 = 1'b0;
    bus_b.cmd_valid  = 1'b0;
    bus_b.cmd_rw     = 1'b0;
    bus_b.cmd_addr   = 32'h0;
    bus_b.cmd_len    = '0;
    bus_b.wr_data    = 32'h0;
    bus_b.wr_valid   = 1'b0;
    bus_b.i2c_master_busy = 1'b0;
    bus_b.i2c_rd_data     = 32'h0;
    bus_b.i2c_rd_valid    = 1'b0;

    repeat (3) @(negedge CLK);
    chk("reset_a", snap_a(), RST_A);
    chk("reset_b_cfg", 128'({bus_b.i2aen, bus_b.i2ac, bus_b.i2dc, bus_b.i2c_slave_addr}),
        128'({1'b1, 2'b01, 2'b01, 7'h2C}));
    rst_n = 1'b1;

    // Single write; upper data bytes must be masked away.
    d0 = done_cnt;
    wr_q.push_back(32'hFFFF_FFA5);
    exp_iss.push_back(mk(32'h10, 32'hA5, RW_WRITE));
    cmd_a(RW_WRITE, 32'h10, 4'd0);
    wait_idle_a("wr1", 200);
    drain_iss("wr1");
    chk("wr1_done", 128'(done_cnt - d0), 128'(1));
    chk("wr1_err", 128'(done_err), 128'(0));

    // Four-word read burst.
    d0 = done_cnt;
    for (i = 0; i < 4; i++) begin
      model_rd.push_back(rd_model[i]);
      exp_rd.push_back(rd_exp[i]);
      exp_iss.push_back(mk(32'h20 + 32'(i), 32'h0, RW_READ));
    end
    cmd_a(RW_READ, 32'h20, 4'd3);
    wait_idle_a("rd4", 200);
    drain_iss("rd4");
    drain_rd("rd4");
    chk("rd4_done", 128'(done_cnt - d0), 128'(1));

    // One-byte address wraps from 0xFF to 0x00.
    wr_q.push_back(32'h5A5A_0001);
    wr_q.push_back(32'h5A5A_0002);
    wr_q.push_back(32'h5A5A_0003);
    exp_iss.push_back(mk(32'hFE, 32'h01, RW_WRITE));
    exp_iss.push_back(mk(32'hFF, 32'h02, RW_WRITE));
    exp_iss.push_back(mk(32'h00, 32'h03, RW_WRITE));
    cmd_a(RW_WRITE, 32'hFE, 4'd2);
    wait_idle_a("wrap", 200);
    drain_iss("wrap");

    // Interface deselected: command must be ignored.
    bus_a.itf_sel_d3 = 1'b1;
    saw_busy = 1'b0;
    cmd_a(RW_READ, 32'h40, 4'd0);
    repeat (10) begin
      @(negedge CLK);
      if (bus_a.busy) saw_busy = 1'b1;
    end
    chk("gate_busy", 128'(saw_busy), 128'(0));
    chk("gate_issue", 128'(obs_iss.size()), 128'(0));
    bus_a.itf_sel_d3 = 1'b0;

    // Write word withheld for 50 cycles: no issue until it arrives.
    hold_wr = 1'b1;
    wr_q.push_back(32'h0000_0077);
    exp_iss.push_back(mk(32'h50, 32'h77, RW_WRITE));
    cmd_a(RW_WRITE, 32'h50, 4'd0);
    repeat (50) @(negedge CLK);
    chk("bp_no_issue", 128'(obs_iss.size()), 128'(0));
    chk("bp_ready", 128'(bus_a.wr_ready), 128'(1));
    hold_wr = 1'b0;
    wait_idle_a("bp", 200);
    drain_iss("bp");

    // Second command during a burst is dropped.
    d0 = done_cnt;
    model_rd.push_back(32'h5E);
    exp_rd.push_back(32'h5E);
    exp_iss.push_back(mk(32'h60, 32'h0, RW_READ));
    cmd_a(RW_READ, 32'h60, 4'd0);
    cmd_a(RW_WRITE, 32'h70, 4'd0);
    wait_idle_a("drop", 200);
    drain_iss("drop");
    drain_rd("drop");
    chk("drop_done", 128'(done_cnt - d0), 128'(1));

    // Wide words on DUT B with an idle master.
    bus_b.wr_data  = 32'hDEAD_BEEF;
    bus_b.wr_valid = 1'b1;
    @(negedge CLK);
    bus_b.cmd_rw    = RW_WRITE;
    bus_b.cmd_addr  = 32'h1234_5678;
    bus_b.cmd_len   = 4'd0;
    bus_b.cmd_valid = 1'b1;
    @(negedge CLK);
    bus_b.cmd_valid = 1'b0;
    for (i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (!bus_b.busy) break;
    end
    bus_b.wr_valid = 1'b0;
    chk("wide_finish", 128'(i < 50), 128'(1));
    chk("wide_count", 128'(obs_iss_b.size()), 128'(1));
    if (obs_iss_b.size() > 0)
      chk("wide_issue", 128'(obs_iss_b.pop_front()), 128'(mk(32'h5678, 32'hBEEF, RW_WRITE)));

`ifdef FPGA_I2C_TIMEOUT_EN
    // Master busy stuck high: watchdog ends the burst with err.
    d0 = done_cnt;
    stuck = 1'b1;
    wr_q.push_back(32'h99);
    cmd_a(RW_WRITE, 32'h90, 4'd3);
    wait_idle_a("wd", 150);
    chk("wd_done", 128'(done_cnt - d0), 128'(1));
    chk("wd_err", 128'(done_err), 128'(1));
    chk("wd_err_hold", 128'(bus_a.err), 128'(1));
    chk("wd_no_issue", 128'(obs_iss.size()), 128'(0));
    stuck = 1'b0;
    wr_q.delete();
    repeat (3) @(negedge CLK);
    wr_q.push_back(32'h12);
    exp_iss.push_back(mk(32'h91, 32'h12, RW_WRITE));
    cmd_a(RW_WRITE, 32'h91, 4'd0);
    wait_idle_a("wd_next", 200);
    drain_iss("wd_next");
    chk("wd_err_clear", 128'(bus_a.err), 128'(0));
`endif

    // Reset in the middle of a read burst.
    for (i = 0; i < 4; i++) model_rd.push_back(rd_model[i]);
    cmd_a(RW_READ, 32'h80, 4'd3);
    for (i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (obs_rd.size() > 0) break;
    end
    chk("rstmid_first_rd", 128'(i < 100), 128'(1));
    repeat (4) @(negedge CLK);
    rst_n = 1'b0;
    #1;
    chk("rstmid_outputs", snap_a(), RST_A);
    obs_rd.delete();
    obs_iss.delete();
    d0 = done_cnt;
    @(negedge CLK);
    rst_n = 1'b1;
    repeat (20) @(negedge CLK);
    chk("rstmid_no_done", 128'(done_cnt - d0), 128'(0));
    chk("rstmid_no_rd", 128'(obs_rd.size()), 128'(0));
    chk("rstmid_idle", 128'(bus_a.busy), 128'(0));
    model_rd.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
